adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture_pkg.sv | 25 ++
 rtl/adc_bitrev_reg.sv | 37 +++
 rtl/adc_capture.sv | 169 ++++++++++++++++
 tb/tb_adc_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared mode codes and FSM encodings for the ADC capture and DAC output blocks.
package adc_capture_pkg;

  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [CTRL_W-1:0] {
    MODE_IDLE    = 8'd0,
    MODE_STREAM  = 8'd1,
    MODE_CAPTURE = 8'd2
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // A decimation factor of zero behaves like one.
  function automatic logic [CTRL_W-1:0] decim_eff(input logic [CTRL_W-1:0] d);
    return (d == '0) ? CTRL_W'(1) : d;
  endfunction

endpackage

// File: rtl/adc_bitrev_reg.sv
// ADC pin input register; reverses bit order so the pin LSB lands in the sample MSB.
module adc_bitrev_reg #(
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] pins_i,
  input  logic              otr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              otr_o
);

  logic [DATA_W-1:0] rev_c;
  logic [DATA_W-1:0] data_q;
  logic              otr_q;

  always_comb begin
    rev_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      rev_c[i] = pins_i[DATA_W-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
      otr_q  <= 1'b0;
    end else begin
      data_q <= rev_c;
      otr_q  <= otr_i;
    end
  end

  assign data_o = data_q;
  assign otr_o  = otr_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture: registered pin input, decimation, stream/block capture FSM and a
// single-entry valid/ready output register with sticky overflow/overrange flags.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        control,
  input  logic [DATA_W-1:0] adc_out,
  input  logic              adc_otr,
  output logic              clk_out,
  input  logic [7:0]        decim,
  input  logic [LEN_W-1:0]  block_len,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              overrange
);

  localparam int unsigned DCNT_W = 8;

  logic [DATA_W-1:0] din_q;
  logic              otr_q;

  state_e             state_q, state_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [DCNT_W-1:0]  n_q, n_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic active_c;
  logic produce_c;
  logic entry_c;

  adc_bitrev_reg #(
    .DATA_W (DATA_W)
  ) u_bitrev (
    .clk    (clk),
    .resetn (resetn),
    .pins_i (adc_out),
    .otr_i  (adc_otr),
    .data_o (din_q),
    .otr_o  (otr_q)
  );

  assign clk_out = clk;

  // Next state, counters and the output handshake stage.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    n_d      = n_q;
    bcnt_d   = bcnt_q;
    len_d    = len_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ovr_d    = ovr_q;
    entry_c  = 1'b0;

    active_c  = (state_q == ST_STREAM) || (state_q == ST_CAPTURE);
    produce_c = active_c && (dcnt_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (control == MODE_STREAM) begin
          state_d = ST_STREAM;
          entry_c = 1'b1;
        end else if (control == MODE_CAPTURE) begin
          state_d = ST_CAPTURE;
          entry_c = 1'b1;
        end
      end
      ST_STREAM: begin
        if (control != MODE_STREAM) state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (control != MODE_CAPTURE) begin
          state_d = ST_IDLE;
        end else if (produce_c && (bcnt_q == len_q - LEN_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (control != MODE_CAPTURE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (active_c) begin
      dcnt_d = (dcnt_q == n_q - DCNT_W'(1)) ? '0 : dcnt_q + DCNT_W'(1);
      if (produce_c) bcnt_d = bcnt_q + LEN_W'(1);
    end

    // A produced sample either loads (slot free or draining this cycle) or is dropped.
    if (produce_c) begin
      if (!valid_q || sample_ready) begin
        sample_d = din_q;
        valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
      if (otr_q) ovr_d = 1'b1;
    end else if (sample_ready) begin
      valid_d = 1'b0;
    end

    // Run parameters are frozen at entry; sticky flags restart with each run.
    if (entry_c) begin
      dcnt_d = '0;
      bcnt_d = '0;
      n_d    = decim_eff(decim);
      len_d  = (block_len == '0) ? LEN_W'(1) : block_len;
      ovf_d  = 1'b0;
      ovr_d  = 1'b0;
    end

    busy_d = (state_d == ST_STREAM) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      dcnt_q   <= '0;
      n_q      <= '0;
      bcnt_q   <= '0;
      len_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      n_q      <= n_d;
      bcnt_q   <= bcnt_d;
      len_q    <= len_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign overrange    = ovr_q;

endmodule

// File: tb/tb_adc_capture.sv
// Testbench for adc_capture: directed vector tables, hand sequences and a
// randomized run against a cycle-level reference model.
module tb_adc_capture;

  localparam int unsigned DW = 14;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    control;
  logic [DW-1:0] adc_out;
  logic          adc_otr;
  logic          clk_out;
  logic [7:0]    decim;
  logic [LW-1:0] block_len;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          overrange;

  int n_total = 0;
  int n_pass  = 0;

  adc_capture #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .control      (control),
    .adc_out      (adc_out),
    .adc_otr      (adc_otr),
    .clk_out      (clk_out),
    .decim        (decim),
    .block_len    (block_len),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .overrange    (overrange)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    ctrl;
    logic [DW-1:0] pin;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_sample;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tab[$];

  // Reference model: mode 0 idle, 1 stream, 2 capture, 3 done.
  int            m_mode, m_k, m_n, m_len, m_np;
  logic          m_valid, m_ovf, m_ovr, m_otr;
  logic [DW-1:0] m_sample, m_din;

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW); i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_update();
    bit active, prod, entry;
    int nxt;
    if (!resetn) begin
      m_mode = 0; m_k = 0; m_n = 1; m_len = 1; m_np = 0;
      m_valid = 0; m_ovf = 0; m_ovr = 0; m_otr = 0;
      m_sample = '0; m_din = '0;
      return;
    end
    active = (m_mode == 1) || (m_mode == 2);
    prod   = active && ((m_k % m_n) == 0);
    entry  = 0;
    nxt    = m_mode;
    case (m_mode)
      0: if (control == 8'd1) begin nxt = 1; entry = 1; end
         else if (control == 8'd2) begin nxt = 2; entry = 1; end
      1: if (control != 8'd1) nxt = 0;
      2: if (control != 8'd2) nxt = 0;
         else if (prod && (m_np + 1 == m_len)) nxt = 3;
      default: if (control != 8'd2) nxt = 0;
    endcase
    if (prod) begin
      if (!m_valid || sample_ready) begin m_sample = m_din; m_valid = 1; end
      else m_ovf = 1;
      if (m_otr) m_ovr = 1;
    end else if (sample_ready) begin
      m_valid = 0;
    end
    if (active) begin
      m_k++;
      if (prod) m_np++;
    end
    if (entry) begin
      m_k = 0; m_np = 0;
      m_n   = (decim == 0) ? 1 : int'(decim);
      m_len = (block_len == 0) ? 1 : int'(block_len);
      m_ovf = 0; m_ovr = 0;
    end
    m_mode = nxt;
    m_din  = rev(adc_out);
    m_otr  = adc_otr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic go_idle();
    control = 8'd0; sample_ready = 1'b1; adc_otr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_table(input string nm);
    foreach (tab[i]) begin
      control = tab[i].ctrl; adc_out = rev(tab[i].pin); sample_ready = tab[i].rdy;
      tick();
      chk({nm, "_valid"}, 32'(sample_valid), 32'(tab[i].e_valid));
      if (tab[i].e_valid) chk({nm, "_sample"}, 32'(sample), 32'(tab[i].e_sample));
      chk({nm, "_busy"}, 32'(busy), 32'(tab[i].e_busy));
      chk({nm, "_done"}, 32'(done), 32'(tab[i].e_done));
    end
    tab.delete();
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0; control = 8'd0; adc_out = '0; adc_otr = 1'b0;
    decim = 8'd1; block_len = 16'd1; sample_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ovr", 32'(overrange), 32'd0);
    chk("clk_out", 32'(clk_out), 32'(clk));
    resetn = 1'b1;
    go_idle();

    // Stream ramp, N=1: pin i appears after edge i+1, valid every cycle.
    decim = 8'd1;
    for (int i = 0; i < 10; i++) begin
      v.ctrl = 8'd1; v.pin = DW'(100 + i); v.rdy = 1'b1;
      v.e_valid = (i >= 1); v.e_sample = DW'(100 + i - 1);
      v.e_busy = 1'b1; v.e_done = 1'b0;
      tab.push_back(v);
    end
    run_table("stream");
    go_idle();

    // Capture block_len=4, N=3: samples at edges 1,4,7,10, then DONE.
    decim = 8'd3; block_len = 16'd4;
    for (int i = 0; i < 14; i++) begin
      v.ctrl = 8'd2; v.pin = DW'(200 + i); v.rdy = 1'b1;
      v.e_valid = (i >= 1) && (i <= 10) && ((i - 1) % 3 == 0);
      v.e_sample = DW'(200 + i - 1);
      v.e_busy = (i <= 9); v.e_done = (i >= 10);
      tab.push_back(v);
    end
    run_table("capture");
    go_idle();
    chk("capture_exit_done", 32'(done), 32'd0);

    // Backpressure: first sample held, later ones dropped, then no-bubble reload.
    decim = 8'd1; control = 8'd1; sample_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adc_out = rev(DW'(300 + i));
      tick();
    end
    chk("bp_hold_sample", 32'(sample), 32'd300);
    chk("bp_hold_valid", 32'(sample_valid), 32'd1);
    chk("bp_overflow", 32'(overflow), 32'd1);
    adc_out = rev(DW'(306)); sample_ready = 1'b1;
    tick();
    chk("bp_reload_sample", 32'(sample), 32'd305);
    chk("bp_reload_valid", 32'(sample_valid), 32'd1);
    control = 8'd0;
    tick();
    chk("drain_sample", 32'(sample), 32'd306);
    chk("drain_valid", 32'(sample_valid), 32'd1);
    tick();
    chk("drain_empty", 32'(sample_valid), 32'd0);
    chk("ovf_sticky_idle", 32'(overflow), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Overrange pulse: sticky until the next entry.
    control = 8'd1;
    tick();
    chk("entry_clears_ovf", 32'(overflow), 32'd0);
    tick();
    adc_otr = 1'b1; tick(); adc_otr = 1'b0;
    repeat (3) tick();
    chk("ovr_set", 32'(overrange), 32'd1);
    control = 8'd0; repeat (2) tick();
    chk("ovr_sticky_idle", 32'(overrange), 32'd1);
    control = 8'd1; tick();
    chk("entry_clears_ovr", 32'(overrange), 32'd0);
    go_idle();

    // Reset in the middle of a long capture.
    decim = 8'd1; block_len = 16'd100; control = 8'd2;
    for (int i = 0; i < 51; i++) begin
      adc_out = rev(DW'(400 + i)); tick();
    end
    chk("cap50_sample", 32'(sample), 32'd449);
    chk("cap50_busy", 32'(busy), 32'd1);
    resetn = 1'b0; tick();
    chk("midrst_sample", 32'(sample), 32'd0);
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    resetn = 1'b1; control = 8'd0;
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);
    go_idle();

    // decim=0 and block_len=0 behave as one.
    decim = 8'd0; block_len = 16'd0; control = 8'd2;
    adc_out = rev(DW'(77)); tick();
    adc_out = rev(DW'(78)); tick();
    chk("zero_sample", 32'(sample), 32'd77);
    chk("zero_valid", 32'(sample_valid), 32'd1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_single", 32'(sample_valid), 32'd0);
    go_idle();

    // Randomized run against the reference model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: control = 8'd0;
          1, 3: control = 8'd1;
          2, 4: control = 8'd2;
          default: control = 8'd0;
        endcase
        if ($urandom_range(0, 7) == 0) control = 8'($urandom_range(3, 255));
      end
      if ($urandom_range(0, 9) == 0) decim = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) block_len = LW'($urandom_range(0, 6));
      adc_out      = DW'($urandom);
      adc_otr      = ($urandom_range(0, 19) == 0);
      sample_ready = ($urandom_range(0, 3) != 0);
      resetn       = ($urandom_range(0, 299) != 0);
      tick();
      chk("rnd_valid", 32'(sample_valid), 32'(m_valid));
      if (m_valid) chk("rnd_sample", 32'(sample), 32'(m_sample));
      chk("rnd_busy", 32'(busy), 32'((m_mode == 1) || (m_mode == 2)));
      chk("rnd_done", 32'(done), 32'(m_mode == 3));
      chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
      chk("rnd_ovr", 32'(overrange), 32'(m_ovr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
